// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one cache slave port among NREQ requesters.
// Optional watchdog enabled by defining CACHE_ARB_TIMEOUT_EN.
module cache_arbiter #(
    parameter int NREQ     = 4,
    parameter int ADDRBITS = 32,
    parameter int DATABITS = 32,
    parameter int TIMEOUT  = 1024
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_request,
    input  logic [2*NREQ-1:0]        req_operation,
    input  logic [ADDRBITS*NREQ-1:0] req_addr,
    input  logic [DATABITS*NREQ-1:0] req_wdata,
    output logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_error,
    output logic [DATABITS-1:0]      req_rdata,
    output logic [$clog2(NREQ)-1:0]  grant_id,
    output logic                     cache_request,
    output logic [1:0]               cache_operation,
    output logic [ADDRBITS-1:0]      cache_addr,
    output logic [DATABITS-1:0]      cache_wdata,
    input  logic [DATABITS-1:0]      cache_rdata,
    input  logic                     cache_valid,
    input  logic                     cache_evict
);

    localparam int IDW = $clog2(NREQ);
    localparam logic [1:0] OP_NOP  = 2'd0;
    localparam logic [1:0] OP_READ = 2'd1;

    if (NREQ < 2 || NREQ > 16 || TIMEOUT < 2) begin : gBadParams
        $error("cache_arbiter: NREQ must be 2..16 and TIMEOUT at least 2");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                state_q, state_d;
    logic [IDW-1:0]        rrPtr_q, grantId_q, rrNext;
    logic [1:0]            op_q;
    logic [ADDRBITS-1:0]   addr_q;
    logic [DATABITS-1:0]   wdata_q, rdata_q;
    logic                  grantEn, rdataEn, timeoutHit, errFlag, found;
    logic [IDW-1:0]        winner, cand;
    logic [NREQ-1:0]       ownerOnehot;
    logic [1:0]            opArr    [NREQ];
    logic [ADDRBITS-1:0]   addrArr  [NREQ];
    logic [DATABITS-1:0]   wdataArr [NREQ];

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            opArr[i]    = req_operation[2*i +: 2];
            addrArr[i]  = req_addr[ADDRBITS*i +: ADDRBITS];
            wdataArr[i] = req_wdata[DATABITS*i +: DATABITS];
        end
    end

    // Scan from rrPtr_q upward, wrapping, and take the first active request.
    always_comb begin
        int idx;
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        idx    = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(rrPtr_q) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            cand = IDW'(idx);
            if (!found && req_request[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grantEn = 1'b0;
        rdataEn = 1'b0;
        case (state_q)
            IDLE: begin
                if (!cache_evict && found) begin
                    grantEn = 1'b1;
                    state_d = (opArr[winner] == OP_NOP) ? RESP : ISSUE;
                end
            end
            ISSUE, WAIT: begin
                if (cache_valid) begin
                    state_d = RESP;
                    rdataEn = (op_q == OP_READ);
                end else if (timeoutHit) begin
                    state_d = RESP;
                end else begin
                    state_d = WAIT;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign rrNext = (grantId_q == IDW'(NREQ - 1)) ? '0 : grantId_q + IDW'(1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            rrPtr_q   <= '0;
            grantId_q <= '0;
            op_q      <= OP_NOP;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
        end else begin
            state_q <= state_d;
            if (grantEn) begin
                grantId_q <= winner;
                op_q      <= opArr[winner];
                addr_q    <= addrArr[winner];
                wdata_q   <= wdataArr[winner];
            end
            if (state_q == RESP) rrPtr_q <= rrNext;
            if (rdataEn) rdata_q <= cache_rdata;
        end
    end

`ifdef CACHE_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TLIMIT = TW'(TIMEOUT - 1);

    logic [TW-1:0] timer_q, timer_d;
    logic          err_q, err_d;

    // The timer counts cycles spent waiting on the cache; err_q marks a watchdog exit.
    always_comb begin
        timer_d = timer_q;
        err_d   = err_q;
        if (grantEn) begin
            timer_d = '0;
            err_d   = 1'b0;
        end else if (cache_request) begin
            timer_d = timer_q + TW'(1);
            if (!cache_valid && timeoutHit) err_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            timer_q <= '0;
            err_q   <= 1'b0;
        end else begin
            timer_q <= timer_d;
            err_q   <= err_d;
        end
    end

    assign timeoutHit = (timer_q == TLIMIT);
    assign errFlag    = err_q;
    assign req_error  = (state_q == RESP && err_q) ? ownerOnehot : '0;
`else
    assign timeoutHit = 1'b0;
    assign errFlag    = 1'b0;
    assign req_error  = '0;
`endif

    assign ownerOnehot     = NREQ'(1) << grantId_q;
    assign req_valid       = (state_q == RESP && !errFlag) ? ownerOnehot : '0;
    assign req_rdata       = rdata_q;
    assign grant_id        = grantId_q;
    assign cache_request   = (state_q == ISSUE) || (state_q == WAIT);
    assign cache_operation = op_q;
    assign cache_addr      = addr_q;
    assign cache_wdata     = wdata_q;

endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Round-robin arbiter that shares a single cache slave port among NREQ requesters (CPU instruction/data ports or multiple cores). Sits directly in front of the L1 `cache` block. It grants one requester at a time, forwards its operation/address/data to the cache, and holds the grant until the cache signals `valid`. It then returns read data and a one-cycle completion pulse to the owner. New grants are blocked while the cache is servicing a next-level eviction.

## Interface
- NREQ, 4: number of requesters, 2..16
- ADDRBITS, 32: address width
- DATABITS, 32: data word width
- TIMEOUT, 1024: watchdog limit in cycles (used only with CACHE_ARB_TIMEOUT_EN)

Ports:
- clock  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- req_request  in  NREQ  per-requester request level
- req_operation  in  2*NREQ  per-requester op: 0 NOP, 1 READ, 2 WRITE
- req_addr  in  ADDRBITS*NREQ  per-requester address
- req_wdata  in  DATABITS*NREQ  per-requester write data
- req_valid  out  NREQ  one-cycle completion pulse to owner
- req_error  out  NREQ  one-cycle timeout pulse to owner
- req_rdata  out  DATABITS  read data, broadcast; qualified by req_valid
- grant_id  out  $clog2(NREQ)  current/last owner index
- cache_request  out  1  request to cache
- cache_operation  out  2  op to cache
- cache_addr  out  ADDRBITS  address to cache
- cache_wdata  out  DATABITS  write data to cache
- cache_rdata  in  DATABITS  read data from cache
- cache_valid  in  1  cache transaction complete
- cache_evict  in  1  cache servicing an eviction; blocks new grants

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if cache_evict=0 and any req_request bit set, pick the first set bit at or after rr_ptr, wrapping modulo NREQ. Register the winner into grant_id and latch its op/addr/wdata. Go to ISSUE. Otherwise stay in IDLE.
- Requester with req_operation=NOP and request high is granted. The arbiter completes it internally: it goes straight to RESP without asserting cache_request.
- ISSUE: cache_request=1, cache_* driven from the latched values. Next state WAIT, or RESP if cache_valid=1 this cycle.
- WAIT: cache_request held at 1, outputs stable. Go to RESP when cache_valid=1. On that edge, latch cache_rdata into req_rdata on READ only.
- RESP: req_valid[grant_id]=1 for exactly one cycle. rr_ptr <= (grant_id+1) mod NREQ. Go to IDLE.
- Latched operands mean a requester changing or dropping req_request mid-transaction has no effect. The transaction completes and req_valid still pulses.
- cache_evict is sampled only in IDLE. Assertion during ISSUE/WAIT is ignored.
- Reset values: state IDLE, rr_ptr 0, grant_id 0, req_valid 0, req_error 0, req_rdata 0, cache_request 0, cache_operation 0 (NOP), cache_addr 0, cache_wdata 0.
- Reset asserted mid-transaction: all of the above immediately. No completion pulse is issued for the aborted transaction.

## Timing
- Request visible before edge k: grant at edge k, cache_request high cycle k..
- If cache_valid is seen in cycle k+j, req_valid pulses in cycle k+j+1. Minimum request-to-req_valid latency is 2 cycles.
- Back-to-back: after RESP, IDLE needs one cycle, so the next grant comes at the earliest 1 cycle after the req_valid cycle.
- Fairness: with all NREQ requesting continuously, each is served once per NREQ transactions, in index order from rr_ptr.
- cache_request deasserts on the edge following cache_valid.

## Configuration
- CACHE_ARB_TIMEOUT_EN defined: a counter runs in ISSUE/WAIT.
  - If it reaches TIMEOUT cycles without cache_valid, FSM goes to RESP.
  - RESP pulses req_error[grant_id] instead of req_valid, and leaves req_rdata unchanged.
  - cache_request drops, and rr_ptr advances as normal.
  - The counter clears on every entry to ISSUE.
- Undefined: no counter; the arbiter waits for cache_valid indefinitely, and req_error is tied to 0.

## Test plan
- Reset: hold reset=0 with requests active. All outputs at reset values, no cache_request. Release reset: first grant goes to the lowest requesting index from rr_ptr=0.
- Single READ: req 2 READ addr 0x100, cache_valid after 3 cycles with rdata 0xDEADBEEF. Expect grant_id=2, req_valid[2] one cycle, req_rdata=0xDEADBEEF, exactly one cache_request burst.
- Round-robin: all 4 requesting WRITE continuously. Service order 0,1,2,3,0. Each cache_wdata matches the owner's req_wdata.
- Evict block: cache_evict=1 for 5 cycles with req 1 pending. No grant during those 5 cycles; grant on the first IDLE cycle with evict low. Evict raised during WAIT does not abort.
- Mid-operation drop: req 3 deasserts request in WAIT. Transaction completes and req_valid[3] pulses. Reset asserted in WAIT: cache_request drops immediately and no req_valid pulse follows.
- Timeout (CACHE_ARB_TIMEOUT_EN, TIMEOUT=8): never assert cache_valid. req_error[owner] pulses 8 cycles after ISSUE entry, and the next requester is then granted.
